// File: rtl/mos_pkg.sv
// ============================================================================
// mos_pkg : flag indices, branch opcodes and sequencer state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package mos_pkg;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

  typedef enum logic [2:0] {
    OP_BCC = 3'd0,
    OP_BCS = 3'd1,
    OP_BEQ = 3'd2,
    OP_BMI = 3'd3,
    OP_BNE = 3'd4,
    OP_BPL = 3'd5,
    OP_BVC = 3'd6,
    OP_BVS = 3'd7
  } branch_op_e;

  typedef logic [1:0] seq_state_t;

  localparam seq_state_t S_IDLE = 2'd0;
  localparam seq_state_t S_ADD  = 2'd1;
  localparam seq_state_t S_FIX  = 2'd2;
  localparam seq_state_t S_DONE = 2'd3;

endpackage

`default_nettype wire

// File: rtl/branch_cond_eval.sv
// ============================================================================
// branch_cond_eval : combinational 6502 branch condition from status flags
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_cond_eval
  import mos_pkg::*;
#(
  parameter int C_BIT = FLAG_C,
  parameter int Z_BIT = FLAG_Z,
  parameter int V_BIT = FLAG_V,
  parameter int N_BIT = FLAG_N
) (
  input  logic [2:0] i_op,
  input  logic [7:0] i_status,
  input  logic       i_uncon,
  output logic       o_cond
);

  logic w_flag;
  // Status bits outside the four flags are intentionally ignored.
  logic w_unused_status;

  assign w_unused_status = ^i_status;

  always_comb begin
    w_flag = 1'b0;
    case (i_op)
      OP_BCC:  w_flag = ~i_status[C_BIT];
      OP_BCS:  w_flag =  i_status[C_BIT];
      OP_BEQ:  w_flag =  i_status[Z_BIT];
      OP_BMI:  w_flag =  i_status[N_BIT];
      OP_BNE:  w_flag = ~i_status[Z_BIT];
      OP_BPL:  w_flag = ~i_status[N_BIT];
      OP_BVC:  w_flag = ~i_status[V_BIT];
      OP_BVS:  w_flag =  i_status[V_BIT];
      default: w_flag = 1'b0;
    endcase
  end

  assign o_cond = i_uncon | w_flag;

endmodule

`default_nettype wire

// File: rtl/branch_sequencer.sv
// ============================================================================
// branch_sequencer : relative-branch sequencer for the PC datapath (2/3/4 cycles)
// Rev 1.0
// ============================================================================
`default_nettype none

module branch_sequencer
  import mos_pkg::*;
#(
  parameter int C_BIT = FLAG_C,
  parameter int Z_BIT = FLAG_Z,
  parameter int V_BIT = FLAG_V,
  parameter int N_BIT = FLAG_N
) (
  input  logic       clk_2,
  input  logic       rst,
  input  logic       start,
  input  logic       branch_uncon,
  input  logic [2:0] branch_op,
  input  logic [7:0] status,
  input  logic [7:0] data_bus,
  input  logic [7:0] pc_lo,
  input  logic [7:0] pc_hi,
  output logic [7:0] pc_lo_out,
  output logic [7:0] pc_hi_out,
  output logic       pc_load_lo,
  output logic       pc_load_hi,
  output logic       busy,
  output logic       taken,
  output logic       page_cross,
  output logic       done
);

  seq_state_t r_state;
  seq_state_t w_next;

  logic [7:0] r_off;
  logic [7:0] r_pcl;
  logic [7:0] r_pch;
  logic [7:0] r_pc_lo_hold;
  logic [7:0] r_pc_hi_hold;
  logic       r_taken;

  logic       w_cond;
  logic [8:0] w_sum;
  logic       w_cross;
  logic [7:0] w_pch_new;

  branch_cond_eval #(
    .C_BIT (C_BIT),
    .Z_BIT (Z_BIT),
    .V_BIT (V_BIT),
    .N_BIT (N_BIT)
  ) u_cond (
    .i_op     (branch_op),
    .i_status (status),
    .i_uncon  (branch_uncon),
    .o_cond   (w_cond)
  );

  // Carry out of PCL disagreeing with the offset sign means PCH must move.
  assign w_sum     = {1'b0, r_pcl} + {1'b0, r_off};
  assign w_cross   = w_sum[8] ^ r_off[7];
  assign w_pch_new = r_off[7] ? (r_pch - 8'd1) : (r_pch + 8'd1);

  always_ff @(negedge clk_2 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_cond ? S_ADD : S_DONE;
      S_ADD:   w_next = w_cross ? S_FIX : S_DONE;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // New PC bytes are presented live alongside their strobe, then held.
  always_comb begin
    busy       = (r_state != S_IDLE);
    pc_load_lo = (r_state == S_ADD);
    pc_load_hi = (r_state == S_FIX);
    page_cross = (r_state == S_FIX);
    done       = (r_state == S_DONE);
    pc_lo_out  = (r_state == S_ADD) ? w_sum[7:0] : r_pc_lo_hold;
    pc_hi_out  = (r_state == S_FIX) ? w_pch_new  : r_pc_hi_hold;
  end

  always_ff @(negedge clk_2 or posedge rst) begin
    if (rst) begin
      r_off        <= 8'h00;
      r_pcl        <= 8'h00;
      r_pch        <= 8'h00;
      r_pc_lo_hold <= 8'h00;
      r_pc_hi_hold <= 8'h00;
      r_taken      <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_off   <= data_bus;
        r_pcl   <= pc_lo;
        r_pch   <= pc_hi;
        r_taken <= w_cond;
      end
      if (r_state == S_ADD) begin
        r_pc_lo_hold <= w_sum[7:0];
      end
      if (r_state == S_FIX) begin
        r_pc_hi_hold <= w_pch_new;
      end
    end
  end

  assign taken = r_taken;

endmodule

`default_nettype wire

// File: tb/tb_branch_sequencer.sv
// ============================================================================
// tb_branch_sequencer : directed and randomized checks against a PC-level model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_branch_sequencer;

  logic       clk_2;
  logic       rst;
  logic       start;
  logic       branch_uncon;
  logic [2:0] branch_op;
  logic [7:0] status;
  logic [7:0] data_bus;
  logic [7:0] pc_lo;
  logic [7:0] pc_hi;
  logic [7:0] pc_lo_out;
  logic [7:0] pc_hi_out;
  logic       pc_load_lo;
  logic       pc_load_hi;
  logic       busy;
  logic       taken;
  logic       page_cross;
  logic       done;

  int n_chk;
  int n_pass;

  // Flag tested by each opcode and the value that makes the branch go.
  int flag_idx [8] = '{0, 0, 1, 7, 1, 7, 6, 6};
  bit flag_set [8] = '{0, 1, 1, 1, 0, 0, 0, 1};

  branch_sequencer dut (
    .clk_2        (clk_2),
    .rst          (rst),
    .start        (start),
    .branch_uncon (branch_uncon),
    .branch_op    (branch_op),
    .status       (status),
    .data_bus     (data_bus),
    .pc_lo        (pc_lo),
    .pc_hi        (pc_hi),
    .pc_lo_out    (pc_lo_out),
    .pc_hi_out    (pc_hi_out),
    .pc_load_lo   (pc_load_lo),
    .pc_load_hi   (pc_load_hi),
    .busy         (busy),
    .taken        (taken),
    .page_cross   (page_cross),
    .done         (done)
  );

  initial clk_2 = 1'b1;
  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk_2);
    #1;
  endtask

  task automatic run_branch(input logic uncon, input logic [2:0] op, input logic [7:0] st,
                            input logic [7:0] off, input logic [7:0] pcl, input logic [7:0] pch);
    logic        m_cond;
    logic        m_cross;
    logic [15:0] tgt;
    int          m_cyc;
    int          k;
    int          lo_n, hi_n, overlap, pcx_bad, busy_bad;
    logic [7:0]  lo_v, hi_v;
    bit          seen;

    m_cond  = uncon | (st[flag_idx[op]] == flag_set[op]);
    tgt     = {pch, pcl} + {{8{off[7]}}, off};
    m_cross = m_cond && (tgt[15:8] != pch);
    m_cyc   = !m_cond ? 2 : (m_cross ? 4 : 3);

    start = 1'b1; branch_uncon = uncon; branch_op = op; status = st;
    data_bus = off; pc_lo = pcl; pc_hi = pch;
    tick();
    start = 1'b0;

    lo_n = 0; hi_n = 0; overlap = 0; pcx_bad = 0; busy_bad = 0;
    lo_v = 8'h00; hi_v = 8'h00; seen = 1'b0; k = 1;
    while (!seen && k <= 8) begin
      if (pc_load_lo) begin lo_n++; lo_v = pc_lo_out; end
      if (pc_load_hi) begin hi_n++; hi_v = pc_hi_out; end
      if (pc_load_lo && pc_load_hi) overlap++;
      if (page_cross !== pc_load_hi) pcx_bad++;
      if (!busy) busy_bad++;
      if (done) seen = 1'b1;
      // Noise on every input while busy, including start, must be ignored.
      start = 1'($urandom); status = 8'($urandom); data_bus = 8'($urandom);
      branch_op = 3'($urandom); branch_uncon = 1'($urandom); pc_lo = 8'($urandom);
      if (!seen) k++;
      tick();
    end
    start = 1'b0;

    if (!seen) check("timeout", 32'd0, 32'd1);
    check("taken", 32'(taken), 32'(m_cond));
    check("cycles", 32'(k + 1), 32'(m_cyc));
    check("load_lo_count", 32'(lo_n), m_cond ? 32'd1 : 32'd0);
    check("load_hi_count", 32'(hi_n), m_cross ? 32'd1 : 32'd0);
    if (m_cond)  check("pc_lo_out", 32'(lo_v), 32'(tgt[7:0]));
    if (m_cross) check("pc_hi_out", 32'(hi_v), 32'(tgt[15:8]));
    check("strobe_overlap", 32'(overlap), 32'd0);
    check("page_cross_vs_load_hi", 32'(pcx_bad), 32'd0);
    check("busy_during", 32'(busy_bad), 32'd0);
    check("idle_after", 32'({busy, done}), 32'd0);
  endtask

  initial begin
    int dn;
    logic [7:0] off, pcl, pch;
    n_chk = 0; n_pass = 0;
    rst = 1'b1; start = 1'b0; branch_uncon = 1'b0; branch_op = 3'd0;
    status = 8'h00; data_bus = 8'h00; pc_lo = 8'h00; pc_hi = 8'h00;
    #12;
    check("reset_outputs", {pc_lo_out, pc_hi_out, pc_load_lo, pc_load_hi, busy, taken, page_cross, done}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_outputs", {pc_load_lo, pc_load_hi, busy, taken, page_cross, done}, 32'd0);

    run_branch(1'b0, 3'd0, 8'h00, 8'h05, 8'h10, 8'h12); // bcc taken
    run_branch(1'b0, 3'd2, 8'h00, 8'h05, 8'h10, 8'h12); // beq not taken
    run_branch(1'b0, 3'd4, 8'h00, 8'h10, 8'hF8, 8'h12); // bne forward cross
    run_branch(1'b0, 3'd5, 8'h00, 8'hF0, 8'h05, 8'h12); // bpl backward cross
    run_branch(1'b1, 3'd1, 8'h00, 8'h00, 8'h34, 8'h12); // unconditional, offset 0
    run_branch(1'b0, 3'd1, 8'h01, 8'h01, 8'hFF, 8'hFF); // PC FFFF wraps to 0000
    run_branch(1'b0, 3'd7, 8'h40, 8'h80, 8'h7F, 8'h20); // -128 from 7F crosses
    run_branch(1'b0, 3'd7, 8'h40, 8'h80, 8'h80, 8'h20); // -128 from 80 stays

    // Reset while in FIX: outputs clear at once and the branch never completes.
    start = 1'b1; branch_uncon = 1'b0; branch_op = 3'd4; status = 8'h00;
    data_bus = 8'h10; pc_lo = 8'hF8; pc_hi = 8'h12;
    tick();
    start = 1'b0;
    tick();
    check("in_fix", 32'(page_cross), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {pc_lo_out, pc_hi_out, pc_load_lo, pc_load_hi, busy, taken, page_cross, done}, 32'd0);
    @(posedge clk_2);
    rst = 1'b0;
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || pc_load_lo || pc_load_hi) dn++;
    end
    check("no_activity_after_reset", 32'(dn), 32'd0);
    run_branch(1'b0, 3'd1, 8'h01, 8'h22, 8'h40, 8'h33); // bcs after reset

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(5, 0))
        0:       off = 8'h00;
        1:       off = 8'h80;
        default: off = 8'($urandom);
      endcase
      pcl = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
      case ($urandom_range(3, 0))
        0:       pch = 8'hFF;
        1:       pch = 8'h00;
        default: pch = 8'($urandom);
      endcase
      run_branch(($urandom_range(3, 0) == 0), 3'($urandom), 8'($urandom), off, pcl, pch);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
